// File: rtl/mvm_pkg.sv
// mvm_pkg: shared types and defaults for the MVM stream loader and MVM core bench.
//   send_state_t     - send FSM state encoding
//   mvm_byte_t       - signed 8-bit data byte
//   FRAME_LEN_DEF    - bytes per frame (x[0..3] then A[0..15], row-major)
//   DRAIN_CYCLES_DEF - cycles reserved after core done for y readout
//   TIMEOUT_DEF      - maximum cycles spent waiting for core done
package mvm_pkg;

  localparam int FRAME_LEN_DEF    = 20;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF      = 255;

  typedef logic signed [7:0] mvm_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_WAIT_DONE,
    ST_DRAIN
  } send_state_t;

endpackage

// File: rtl/mvm_frame_buf.sv
// mvm_frame_buf: FRAME_LEN x 8 register file holding one frame.
//   clk   - clock, rising edge
//   we    - write enable
//   waddr - write address
//   wdata - signed write byte
//   raddr - read address
//   rdata - signed read byte, combinational from raddr
// Contents are data only and carry no reset; validity is tracked by the loader.
module mvm_frame_buf
  import mvm_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ADDR_W    = $clog2(FRAME_LEN_DEF)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic        [ADDR_W-1:0] waddr,
  input  logic signed [7:0]        wdata,
  input  logic        [ADDR_W-1:0] raddr,
  output logic signed [7:0]        rdata
);

  mvm_byte_t mem [FRAME_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mvm_stream_loader.sv
// mvm_stream_loader: collects framed upstream bytes into a frame buffer and
// replays each complete frame to the MVM core with a start pulse, then waits
// for core done (with timeout) and a drain window before releasing the buffer.
//   clk, reset           - clock and synchronous active-high reset
//   in_valid/in_data/in_last/in_ready - upstream byte stream
//   mvm_start/mvm_data/mvm_rst        - MVM core control and data
//   mvm_done             - MVM core done flag, honoured only in WAIT_DONE
//   busy                 - send FSM not idle
//   frame_err            - pulse when a misframed upstream frame is dropped
//   timeout_err          - pulse when the core never reports done
//   frames_sent          - frames completed through DRAIN, wrapping
// Build option: MVM_LOADER_DBLBUF_EN selects two ping-pong frame buffers;
// without it a single buffer is used and upstream stalls while it is busy.
module mvm_stream_loader
  import mvm_pkg::*;
#(
  parameter int FRAME_LEN    = FRAME_LEN_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic signed [7:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               mvm_start,
  output logic signed [7:0]  mvm_data,
  input  logic               mvm_done,
  output logic               mvm_rst,
  output logic               busy,
  output logic               frame_err,
  output logic               timeout_err,
  output logic        [15:0] frames_sent
);

  localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
`ifdef MVM_LOADER_DBLBUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  send_state_t       state;
  logic [AW-1:0]     wptr;
  logic              fill_sel;
  logic              send_sel;
  logic [1:0]        full;
  logic [15:0]       cnt;
  logic              accept;
  logic              last_pos;
  logic              complete;
  logic              misalign;
  logic              eligible;
  logic              buf_release;
  logic [AW-1:0]     rd_addr;
  logic signed [7:0] rd_data;
  logic signed [7:0] rd_data0;
  logic              we0;

  // Fill side: the buffer under fill is never full, the buffer under send is
  // always full, so the two sides can never touch the same buffer.
  assign in_ready = ~full[fill_sel];
  assign accept   = in_valid & in_ready;
  assign last_pos = (wptr == AW'(FRAME_LEN - 1));
  assign complete = accept & in_last & last_pos;
  assign misalign = accept & (in_last ^ last_pos);

  // A frame completing this cycle into the buffer next in line counts as
  // available, so IDLE launches START on the very edge it completes.
  assign eligible = full[send_sel] | (complete & (fill_sel == send_sel));

  assign buf_release = ((state == ST_DRAIN) && (cnt == 16'(DRAIN_CYCLES - 1))) ||
                       ((state == ST_WAIT_DONE) && !mvm_done && (cnt == 16'(TIMEOUT - 1)));

  // Read one byte ahead so the registered mvm_data shows byte k in the
  // (k+1)th cycle after START.
  assign rd_addr = ((state == ST_SEND) && (cnt != 16'(FRAME_LEN - 1))) ? AW'(cnt + 16'd1) : '0;

  assign we0 = accept & ~fill_sel;

  mvm_frame_buf #(.FRAME_LEN(FRAME_LEN), .ADDR_W(AW)) u_buf0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data0)
  );

`ifdef MVM_LOADER_DBLBUF_EN
  logic              we1;
  logic signed [7:0] rd_data1;

  assign we1 = accept & fill_sel;

  mvm_frame_buf #(.FRAME_LEN(FRAME_LEN), .ADDR_W(AW)) u_buf1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data1)
  );

  assign rd_data = send_sel ? rd_data1 : rd_data0;
`else
  assign rd_data = rd_data0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      fill_sel  <= 1'b0;
      full      <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      frame_err <= misalign;
      if (accept) wptr <= (in_last | last_pos) ? '0 : wptr + AW'(1);
      if (complete) begin
        full[fill_sel] <= 1'b1;
        if (DBL) fill_sel <= ~fill_sel;
      end
      if (buf_release) full[send_sel] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      send_sel    <= 1'b0;
      cnt         <= '0;
      mvm_start   <= 1'b0;
      mvm_data    <= '0;
      mvm_rst     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frames_sent <= '0;
    end else begin
      mvm_start   <= 1'b0;
      mvm_data    <= '0;
      mvm_rst     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (eligible) begin
            state     <= ST_START;
            mvm_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          state    <= ST_SEND;
          cnt      <= '0;
          mvm_data <= rd_data;
        end
        ST_SEND: begin
          if (cnt == 16'(FRAME_LEN - 1)) begin
            state <= ST_WAIT_DONE;
            cnt   <= '0;
          end else begin
            cnt      <= cnt + 16'd1;
            mvm_data <= rd_data;
          end
        end
        ST_WAIT_DONE: begin
          if (mvm_done) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            mvm_rst     <= 1'b1;
            if (DBL) send_sel <= ~send_sel;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (cnt == 16'(DRAIN_CYCLES - 1)) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            frames_sent <= frames_sent + 16'd1;
            if (DBL) send_sel <= ~send_sel;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_stream_loader.sv
// tb_mvm_stream_loader: directed bench for mvm_stream_loader with default
// parameters (FRAME_LEN=20, DRAIN_CYCLES=4, TIMEOUT=255). Honours
// MVM_LOADER_DBLBUF_EN for the back-to-back frame expectations.
module tb_mvm_stream_loader;
  import mvm_pkg::*;

  localparam int FL = 20;
  localparam int DC = 4;
  localparam int TO = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              mvm_start;
  logic signed [7:0] mvm_data;
  logic              mvm_done = 1'b0;
  logic              mvm_rst;
  logic              busy;
  logic              frame_err;
  logic              timeout_err;
  logic [15:0]       frames_sent;

  int checks = 0;
  int failures = 0;
  int exp_sent = 0;

  always #5 clk = ~clk;

  mvm_stream_loader dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .mvm_start   (mvm_start),
    .mvm_data    (mvm_data),
    .mvm_done    (mvm_done),
    .mvm_rst     (mvm_rst),
    .busy        (busy),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .frames_sent (frames_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic signed [7:0] pat(input int base, input int stride, input int k);
    return 8'(base + stride * k);
  endfunction

  // Offer one byte, wait (bounded) for in_ready, let it be accepted.
  task automatic push(input logic signed [7:0] b, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (in_ready !== 1'b1 && guard < 2000) begin
      step(1);
      guard++;
    end
    if (guard >= 2000) chk("push_ready_wait", 32'(in_ready), 32'd1);
    step(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push_frame(input int base, input int stride);
    for (int k = 0; k < FL; k++) push(pat(base, stride, k), k == FL - 1);
  endtask

  // Entered in the START cycle; leaves in the last SEND cycle (T+20).
  task automatic check_stream(input int base, input int stride, input int done_k);
    chk("start_pulse", 32'(mvm_start), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    for (int k = 0; k < FL; k++) begin
      if (k == done_k) mvm_done = 1'b1;
      step(1);
      mvm_done = 1'b0;
      chk($sformatf("data_%0d", k), 32'(mvm_data), 32'(pat(base, stride, k)));
      if (k == 0) chk("start_one_cycle", 32'(mvm_start), 32'd0);
    end
  endtask

  // Entered at T+20; mvm_done is raised w cycles after WAIT_DONE entry.
  task automatic finish_frame(input int w);
    step(1);
    chk("wait_data_zero", 32'(mvm_data), 32'd0);
    step(w);
    chk("wait_busy", 32'(busy), 32'd1);
    mvm_done = 1'b1;
    step(1);
    mvm_done = 1'b0;
    chk("drain_busy_first", 32'(busy), 32'd1);
    step(DC - 1);
    chk("drain_busy_last", 32'(busy), 32'd1);
    step(1);
    exp_sent++;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("frames_sent", 32'(frames_sent), 32'(exp_sent));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;

    // Reset state
    step(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mvm_start), 32'd0);
    chk("rst_data", 32'(mvm_data), 32'd0);
    chk("rst_mvm_rst", 32'(mvm_rst), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_frames_sent", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    step(1);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Basic frame: bytes 0..19, done at T+30, busy falls at T+35
    push_frame(0, 1);
    check_stream(0, 1, -1);
    finish_frame(9);

    // Early in_last on byte 7 drops the frame
    for (int k = 0; k < 8; k++) push(8'(k), k == 7);
    chk("early_last_err", 32'(frame_err), 32'd1);
    chk("early_last_nostart", 32'(mvm_start), 32'd0);
    chk("early_last_busy", 32'(busy), 32'd0);
    step(1);
    chk("early_last_err_pulse", 32'(frame_err), 32'd0);
    chk("early_last_nostart2", 32'(mvm_start), 32'd0);
    push_frame(-100, 10);
    check_stream(-100, 10, -1);
    finish_frame(3);

    // Missing in_last on byte 19 drops the frame
    for (int k = 0; k < FL; k++) push(8'(k), 1'b0);
    chk("no_last_err", 32'(frame_err), 32'd1);
    chk("no_last_busy", 32'(busy), 32'd0);
    step(1);
    chk("no_last_nostart", 32'(mvm_start), 32'd0);
    push_frame(50, -5);
    check_stream(50, -5, -1);
    finish_frame(0);

    // mvm_done during SEND is ignored
    push_frame(7, 3);
    check_stream(7, 3, 5);
    finish_frame(10);

    // Timeout with mvm_done held low
    push_frame(1, 1);
    check_stream(1, 1, -1);
    step(1);
    step(TO - 1);
    chk("to_before_err", 32'(timeout_err), 32'd0);
    chk("to_before_busy", 32'(busy), 32'd1);
    step(1);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_mvm_rst", 32'(mvm_rst), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_frames_sent", 32'(frames_sent), 32'(exp_sent));
    step(1);
    chk("to_err_pulse", 32'(timeout_err), 32'd0);
    chk("to_rst_pulse", 32'(mvm_rst), 32'd0);
    chk("to_ready", 32'(in_ready), 32'd1);

    // Back-to-back frames with in_valid held high
    push_frame(10, 1);
    in_valid = 1'b1;
    in_data  = pat(-20, 1, 0);
    in_last  = 1'b0;
`ifdef MVM_LOADER_DBLBUF_EN
    chk("b2b_ready_at_start", 32'(in_ready), 32'd1);
    for (int k = 0; k < FL; k++) push(pat(-20, 1, k), k == FL - 1);
    chk("b2b_second_full_ready", 32'(in_ready), 32'd0);
    chk("b2b_first_last_byte", 32'(mvm_data), 32'(pat(10, 1, FL - 1)));
    finish_frame(4);
    step(1);
    check_stream(-20, 1, -1);
    finish_frame(2);
`else
    chk("b2b_ready_at_start", 32'(in_ready), 32'd0);
    check_stream(10, 1, -1);
    chk("b2b_ready_send_end", 32'(in_ready), 32'd0);
    step(1);
    step(4);
    mvm_done = 1'b1;
    step(1);
    mvm_done = 1'b0;
    step(3);
    chk("b2b_ready_drain", 32'(in_ready), 32'd0);
    chk("b2b_busy_drain", 32'(busy), 32'd1);
    step(1);
    exp_sent++;
    chk("b2b_ready_release", 32'(in_ready), 32'd1);
    chk("b2b_busy_release", 32'(busy), 32'd0);
    chk("b2b_frames_sent", 32'(frames_sent), 32'(exp_sent));
    step(1);
    for (int k = 1; k < FL; k++) push(pat(-20, 1, k), k == FL - 1);
    check_stream(-20, 1, -1);
    finish_frame(2);
`endif

    // Reset in the middle of SEND
    push_frame(0, 1);
    chk("mid_rst_start", 32'(mvm_start), 32'd1);
    step(11);
    chk("mid_rst_byte10", 32'(mvm_data), 32'd10);
    reset = 1'b1;
    step(1);
    chk("mid_rst_data", 32'(mvm_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start0", 32'(mvm_start), 32'd0);
    chk("mid_rst_frames", 32'(frames_sent), 32'd0);
    reset = 1'b0;
    exp_sent = 0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (mvm_start === 1'b1) starts++;
    end
    chk("mid_rst_no_start", 32'(starts), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    push_frame(5, 2);
    check_stream(5, 2, -1);
    finish_frame(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mvm_stream_loader.md
MVM_STREAM_LOADER -- requirements
Module: mvm_stream_loader

Interface
REQ-001 Parameter FRAME_LEN, default 20, bytes per frame (x[0..3] then A[0..15], row-major).
REQ-002 Parameter DRAIN_CYCLES, default 4, cycles reserved after core done for y readout.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT_DONE cycles before abort.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 in_valid  input  1  upstream byte valid.
REQ-007 in_data  input  8  signed upstream byte.
REQ-008 in_last  input  1  marks the final byte of an upstream frame.
REQ-009 in_ready  output  1  loader accepts a byte when in_valid and in_ready are both high.
REQ-010 mvm_start  output  1  one-cycle start pulse to the MVM core.
REQ-011 mvm_data  output  8  signed byte stream to the MVM core data input.
REQ-012 mvm_done  input  1  done flag from the MVM core.
REQ-013 mvm_rst  output  1  one-cycle core reset pulse, issued on timeout.
REQ-014 busy  output  1  high whenever the send FSM is not in IDLE.
REQ-015 frame_err  output  1  one-cycle pulse when a frame is dropped for misaligned in_last.
REQ-016 timeout_err  output  1  one-cycle pulse on timeout.
REQ-017 frames_sent  output  16  count of frames completed through DRAIN; wraps 0xFFFF->0.

Function
REQ-018 Fill side: write pointer 0..FRAME_LEN-1; each accepted byte is stored at the pointer and the pointer increments.
REQ-019 in_last on byte FRAME_LEN-1 marks the buffer full and resets the pointer to 0.
REQ-020 in_last on any earlier byte, or its absence on byte FRAME_LEN-1, discards the partial frame, resets the pointer to 0, and pulses frame_err the following cycle.
REQ-021 in_ready is low while no fill buffer is free; it is otherwise high.
REQ-022 Send FSM states: IDLE, START, SEND, WAIT_DONE, DRAIN.
REQ-023 Send FSM transitions: IDLE->START when a full buffer exists; START->SEND after 1 cycle; SEND->WAIT_DONE after FRAME_LEN cycles; WAIT_DONE->DRAIN on mvm_done=1; DRAIN->IDLE after DRAIN_CYCLES cycles.
REQ-024 mvm_start=1 only in START; mvm_data=0 outside SEND.
REQ-025 The byte at index k is driven on mvm_data in the (k+1)th cycle after START (START at T, x[0] at T+1, A[15] at T+20), with no gaps.
REQ-026 mvm_done is ignored in every state except WAIT_DONE.
REQ-027 A wait counter in WAIT_DONE that reaches TIMEOUT without mvm_done produces, in the same edge: timeout_err pulse, mvm_rst pulse, buffer released, state->IDLE, and frames_sent unchanged.
REQ-028 Leaving DRAIN releases the sending buffer and increments frames_sent by 1.
REQ-029 A buffer completing on the same cycle IDLE samples it is eligible that cycle; START follows on the next edge.
REQ-030 Fill and send never access the same buffer simultaneously.

Reset
REQ-031 Reset forces: send FSM to IDLE, all buffers empty, write pointer 0, and all counters 0.
REQ-032 During and after reset, outputs are: in_ready=1 (cycle after reset deasserts), mvm_start=0, mvm_data=0, mvm_rst=0, busy=0, frame_err=0, timeout_err=0, frames_sent=0.
REQ-033 Reset mid-frame or mid-send discards all data; no start pulse is issued for a discarded frame.

Configuration
REQ-034 With MVM_LOADER_DBLBUF_EN defined, there are two frame buffers (ping-pong): the next frame fills while the other is sent, and in_ready is low only when both are full or the free one is being sent.
REQ-035 Without MVM_LOADER_DBLBUF_EN, there is a single buffer: in_ready is low from the accepted in_last until the buffer is released (DRAIN exit or timeout).

Structure
REQ-036 Package mvm_pkg holds: the send-state enum typedef, byte typedef (signed 8-bit), and FRAME_LEN/DRAIN_CYCLES defaults shared with the MVM core bench.
REQ-037 One sub-module, mvm_frame_buf (FRAME_LEN x 8 register file, single write port, single read port), is instantiated once or twice depending on MVM_LOADER_DBLBUF_EN.

Verification
REQ-038 Stream bytes 0..19 with in_last on byte 19 -> start pulse at T, mvm_data=0..19 on T+1..T+20; mvm_done at T+30 -> busy falls at T+35 and frames_sent=1.
REQ-039 in_last on byte 7 -> frame_err pulse, no mvm_start; a following correct frame is sent normally.
REQ-040 mvm_done held 0 -> timeout_err and mvm_rst pulse exactly TIMEOUT cycles after WAIT_DONE entry; frames_sent unchanged.
REQ-041 Two back-to-back frames with in_valid constantly 1 -> with DBLBUF the second frame is fully accepted during the first send; without it, in_ready stays 0 until the first DRAIN exits.
REQ-042 Reset asserted at SEND byte 10 -> mvm_data=0, busy=0, and no further start pulse until a new full frame arrives.
REQ-043 mvm_done pulse during SEND -> ignored; the FSM still waits in WAIT_DONE for the next mvm_done.
